// File: rtl/intc_prio8.sv
// intc_prio8: eight-source priority interrupt controller feeding a single CPU vector input.
// Latency: src rise at edge k -> pending after k -> interrupt/irq after k+1; re-arbitration one cycle after eoi.
// Backpressure: one request at a time; a request not acknowledged within TIMEOUT cycles is withdrawn.
//
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   src[7:0]            : rising-edge event lines, src[0] highest priority
//   mask_we, mask_wdata : mask register write (bit=1 disables that source)
//   int_ack, eoi        : CPU handshake pulses (handler entry, IRET)
//   interrupt, irq      : registered request and vector index to the CPU
//   in_service          : high while a handler runs
//   pending, mask       : pending latch and mask register contents
//   timeout_err         : one-cycle pulse when a request is withdrawn unacknowledged
module intc_prio8 #(
  parameter logic [7:0] MASK_RESET = 8'h00,
  parameter int         TIMEOUT    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] src,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       int_ack,
  input  logic       eoi,
  output logic       interrupt,
  output logic [2:0] irq,
  output logic       in_service,
  output logic [7:0] pending,
  output logic [7:0] mask,
  output logic       timeout_err
);

  // Counter only has to reach TIMEOUT-1; it restarts on every entry to REQ.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    src_d;
  logic [CW-1:0] wait_cnt;

  logic [7:0] rise;
  logic [7:0] eligible;
  logic [7:0] clr;
  logic [2:0] winner;

  assign rise     = src & ~src_d;
  assign eligible = pending & ~mask;

  // Lowest set index wins; scanning downwards leaves the lowest one last.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Only an acknowledge of the live request clears its pending bit.
  always_comb begin
    clr = 8'h00;
    if (state == S_REQ && int_ack) clr[irq] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_d       <= 8'h00;
      pending     <= 8'h00;
      mask        <= MASK_RESET;
      state       <= S_IDLE;
      interrupt   <= 1'b0;
      irq         <= 3'd0;
      in_service  <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      src_d <= src;
      // Clear first, then set: a fresh edge on the acknowledged bit survives.
      pending     <= (pending & ~clr) | rise;
      timeout_err <= 1'b0;
      if (mask_we) mask <= mask_wdata;

      case (state)
        S_IDLE: begin
          if (eligible != 8'h00) begin
            irq       <= winner;
            interrupt <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // Acknowledge takes precedence over an expiring wait.
          if (int_ack) begin
            interrupt  <= 1'b0;
            in_service <= 1'b1;
            state      <= S_SERVICE;
          end else if (wait_cnt == WAIT_LAST) begin
            interrupt   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          interrupt  <= 1'b0;
          in_service <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_prio8.sv
// tb_intc_prio8: directed scenarios plus randomized traffic against a behavioural model.
// Model is evaluated at each posedge from the sampled inputs; outputs compared 1ns after.
// Summary line reports comparison and failure counts.
module tb_intc_prio8;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] src = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic       int_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       interrupt;
  logic [2:0] irq;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       timeout_err;

  intc_prio8 #(.MASK_RESET(8'h00), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .src(src), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_ack(int_ack), .eoi(eoi),
    .interrupt(interrupt), .irq(irq), .in_service(in_service),
    .pending(pending), .mask(mask), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing outstanding, 1 = request raised, 2 = handler running
  int         m_phase;
  int         m_age;       // edges elapsed since the request was raised
  logic [7:0] m_pending, m_mask, m_prev_src;
  logic [2:0] m_irq;
  logic       m_int, m_ins, m_terr;

  always @(posedge clock) begin
    logic [7:0] edges, ready, kill;
    if (reset) begin
      m_phase = 0; m_age = 0; m_pending = 8'h00; m_mask = 8'h00;
      m_prev_src = 8'h00; m_irq = 3'd0; m_int = 1'b0; m_ins = 1'b0; m_terr = 1'b0;
    end else begin
      edges = src & ~m_prev_src;
      m_prev_src = src;
      kill = 8'h00;
      m_terr = 1'b0;
      if (m_phase == 0) begin
        ready = m_pending & ~m_mask;
        for (int i = 0; i < 8; i++) begin
          if (m_phase == 0 && ready[i]) begin
            m_irq = 3'(i); m_int = 1'b1; m_age = 0; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_age++;
        if (int_ack) begin
          kill[m_irq] = 1'b1; m_int = 1'b0; m_ins = 1'b1; m_phase = 2;
        end else if (m_age == TO) begin
          m_int = 1'b0; m_terr = 1'b1; m_phase = 0;
        end
      end else begin
        if (eoi) begin
          m_ins = 1'b0; m_phase = 0;
        end
      end
      if (mask_we) m_mask = mask_wdata;
      m_pending = (m_pending & ~kill) | edges;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always begin
    @(posedge clock);
    #1;
    if (chk_en) begin
      check("interrupt",   {7'd0, interrupt},   {7'd0, m_int});
      check("irq",         {5'd0, irq},         {5'd0, m_irq});
      check("in_service",  {7'd0, in_service},  {7'd0, m_ins});
      check("pending",     pending,             m_pending);
      check("mask",        mask,                m_mask);
      check("timeout_err", {7'd0, timeout_err}, {7'd0, m_terr});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset
    reset = 1'b1; step(); step();
    chk_en = 1'b1;
    reset = 1'b0;
    check("rst_interrupt", {7'd0, interrupt}, 8'h00);
    check("rst_pending", pending, 8'h00);
    check("rst_mask", mask, 8'h00);

    // single source, full handshake
    src = 8'h04; step(); src = 8'h00;
    check("t1_pending_k", pending, 8'h04);
    check("t1_int_k", {7'd0, interrupt}, 8'h00);
    step();
    check("t1_int_k1", {7'd0, interrupt}, 8'h01);
    check("t1_irq", {5'd0, irq}, 8'h02);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("t1_pending_ack", pending, 8'h00);
    check("t1_insvc", {7'd0, in_service}, 8'h01);
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t1_insvc_eoi", {7'd0, in_service}, 8'h00);
    step();
    check("t1_int_quiet", {7'd0, interrupt}, 8'h00);

    // two simultaneous sources
    src = 8'h28; step(); src = 8'h00; step();
    check("t2_irq3", {5'd0, irq}, 8'h03);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t2_int_eoi", {7'd0, interrupt}, 8'h00);
    step();
    check("t2_int_rereq", {7'd0, interrupt}, 8'h01);
    check("t2_irq5", {5'd0, irq}, 8'h05);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t2_pending_end", pending, 8'h00);

    // masking
    mask_we = 1'b1; mask_wdata = 8'h01; step(); mask_we = 1'b0;
    src = 8'h01; step();
    check("t3_masked_int", {7'd0, interrupt}, 8'h00);
    src = 8'h03; step(); src = 8'h00;
    check("t3_pending", pending, 8'h03);
    step();
    check("t3_irq1", {5'd0, irq}, 8'h01);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    mask_we = 1'b1; mask_wdata = 8'h00; step(); mask_we = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0; step();
    check("t3_irq0", {5'd0, irq}, 8'h00);
    check("t3_int", {7'd0, interrupt}, 8'h01);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // timeout
    src = 8'h40; step(); src = 8'h00; step();
    check("t4_irq6", {5'd0, irq}, 8'h06);
    for (int i = 0; i < TO - 1; i++) step();
    check("t4_int_held", {7'd0, interrupt}, 8'h01);
    step();
    check("t4_int_drop", {7'd0, interrupt}, 8'h00);
    check("t4_terr", {7'd0, timeout_err}, 8'h01);
    check("t4_pending", pending, 8'h40);
    step();
    check("t4_rereq", {7'd0, interrupt}, 8'h01);
    check("t4_terr_once", {7'd0, timeout_err}, 8'h00);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // set beats clear on the acknowledged bit
    src = 8'h04; step(); src = 8'h00; step();
    src = 8'h04; int_ack = 1'b1; step(); src = 8'h00; int_ack = 1'b0;
    check("t5_pending_set", pending, 8'h04);
    eoi = 1'b1; step(); eoi = 1'b0; step();
    check("t5_irq2_again", {5'd0, irq}, 8'h02);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // reset during service
    src = 8'h11; step(); src = 8'h00; step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    src = 8'h01; step(); src = 8'h00;
    check("t6_pending11", pending, 8'h11);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_pending", pending, 8'h00);
    check("t6_rst_insvc", {7'd0, in_service}, 8'h00);
    eoi = 1'b1; step(); eoi = 1'b0;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("t6_stray_int", {7'd0, interrupt}, 8'h00);
    check("t6_stray_pending", pending, 8'h00);

    // randomized traffic: first phase acks often, second rarely (forces timeouts)
    for (int c = 0; c < 3000; c++) begin
      src        = 8'($urandom & $urandom & $urandom);
      int_ack    = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      mask_we    = ($urandom_range(0, 29) == 0);
      mask_wdata = 8'($urandom & $urandom);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; src = 8'h00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
